// File: rtl/div_16bit_stream.sv
// rtl/div_16bit_stream.sv - operand FIFO, issue and output registers around an external divider; optional DIV_ZERO_CHECK_EN
module div_16bit_stream #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        in_ready,
    output logic [15:0] div_a,
    output logic [15:0] div_b,
    input  logic [15:0] div_q,
    input  logic [15:0] div_r,
    output logic        out_valid,
    output logic [15:0] out_q,
    output logic [15:0] out_r,
    output logic        out_err,
    input  logic        out_ready,
    output logic        busy,
    output logic [15:0] done_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          iss_valid;
    logic [15:0]   iss_a;
    logic [15:0]   iss_b;
    logic          out_move;
    logic          out_take;
    logic [15:0]   res_q;
    logic [15:0]   res_r;
    logic          res_err;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CW'(DEPTH));
    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready;
    assign out_take   = out_valid && out_ready;
    // The issued pair advances whenever the output slot is free or being drained this cycle
    assign out_move   = iss_valid && (!out_valid || out_ready);
    assign pop        = !fifo_empty && (!iss_valid || out_move);
    assign busy       = !fifo_empty || iss_valid || out_valid;
    assign div_a      = iss_a;
    assign div_b      = iss_b;

`ifdef DIV_ZERO_CHECK_EN
    // A zero divisor overrides whatever the external divider returns
    assign res_err = (iss_b == 16'h0000);
    assign res_q   = res_err ? 16'hFFFF : div_q;
    assign res_r   = res_err ? iss_a : div_r;
`else
    assign res_err = 1'b0;
    assign res_q   = div_q;
    assign res_r   = div_r;
`endif

    // Operand storage; contents are meaningless until counted in, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + 1'b1;
            end else if (!push && pop) begin
                fifo_cnt <= fifo_cnt - 1'b1;
            end
        end
    end

    // Issue register; operands are held after the entry leaves so the divider inputs stay quiet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid <= 1'b0;
            iss_a     <= 16'h0000;
            iss_b     <= 16'h0000;
        end else if (pop) begin
            iss_valid      <= 1'b1;
            {iss_a, iss_b} <= mem[rd_ptr];
        end else if (out_move) begin
            iss_valid <= 1'b0;
        end
    end

    // Output register and completed-transfer counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_q     <= 16'h0000;
            out_r     <= 16'h0000;
            out_err   <= 1'b0;
            done_cnt  <= 16'h0000;
        end else begin
            if (out_move) begin
                out_valid <= 1'b1;
                out_q     <= res_q;
                out_r     <= res_r;
                out_err   <= res_err;
            end else if (out_take) begin
                out_valid <= 1'b0;
            end
            if (out_take) begin
                done_cnt <= done_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_div_16bit_stream.sv
// tb/tb_div_16bit_stream.sv - directed self-checking bench for div_16bit_stream
module tb_div_16bit_stream;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_a = 16'h0;
    logic [15:0] in_b = 16'h0;
    logic        in_ready;
    logic [15:0] div_a;
    logic [15:0] div_b;
    logic [15:0] div_q;
    logic [15:0] div_r;
    logic        out_valid;
    logic [15:0] out_q;
    logic [15:0] out_r;
    logic        out_err;
    logic        out_ready = 1'b0;
    logic        busy;
    logic [15:0] done_cnt;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_cyc = -1;
    bit          consec_en = 1'b0;
    logic [32:0] exp_q [$];
    logic [15:0] va [7];
    logic [15:0] vb [7];
    int          acc;
    bit          ok;

    div_16bit_stream #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .in_ready(in_ready), .div_a(div_a), .div_b(div_b), .div_q(div_q), .div_r(div_r),
        .out_valid(out_valid), .out_q(out_q), .out_r(out_r), .out_err(out_err),
        .out_ready(out_ready), .busy(busy), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // External divider; zero divisor returns a recognisable junk pattern
    assign div_q = (div_b == 16'h0) ? 16'h0BAD : div_a / div_b;
    assign div_r = (div_b == 16'h0) ? 16'h0F00 : div_a % div_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [15:0] a, input logic [15:0] b);
        if (b == 16'h0) begin
`ifdef DIV_ZERO_CHECK_EN
            return {16'hFFFF, a, 1'b1};
`else
            return {16'h0BAD, 16'h0F00, 1'b0};
`endif
        end
        return {a / b, a % b, 1'b0};
    endfunction

    // Scoreboard: a transfer seen at the negedge completes at the following posedge
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_out", {31'h0, out_valid}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("sb_q", out_q, e[32:17]);
                check("sb_r", out_r, e[16:1]);
                check("sb_err", out_err, e[0]);
            end
            if (consec_en) begin
                if (last_cyc >= 0) check("consec", cyc - last_cyc, 1);
                last_cyc = cyc;
            end
        end
    end

    task automatic push(input logic [15:0] a, input logic [15:0] b, input int bound, output bit acc_ok);
        acc_ok = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc_ok = 1'b1;
                break;
            end
        end
        if (acc_ok) begin
            @(posedge clk);
            #1;
            exp_q.push_back(model(a, b));
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        bit done;
        done = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check("drain_done", {31'h0, done}, 32'h1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        va = '{16'd50, 16'd77, 16'd1000, 16'd65535, 16'd9, 16'd17, 16'd200};
        vb = '{16'd5,  16'd10, 16'd33,   16'd2,     16'd9, 16'd4,  16'd3};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done_cnt", done_cnt, 0);
        check("rst_out_qr", {out_q, out_r}, 0);
        check("rst_div_ab", {div_a, div_b}, 0);
        check("rst_out_err", out_err, 0);
        rst_n = 1'b1;

        // Single op, idle-pipe latency, accepted at the first edge after release
        out_ready = 1'b1;
        push(16'd100, 16'd7, 1, ok);
        check("single_first_edge", {31'h0, ok}, 1);
        check("single_lat0_valid", out_valid, 0);
        check("single_busy", busy, 1);
        @(posedge clk); #1;
        check("single_div_ab", {div_a, div_b}, {16'd100, 16'd7});
        check("single_lat1_valid", out_valid, 0);
        @(posedge clk); #1;
        check("single_lat2_valid", out_valid, 1);
        check("single_q", out_q, 14);
        check("single_r", out_r, 2);
        check("single_err", out_err, 0);
        check("div_hold", {div_a, div_b}, {16'd100, 16'd7});
        wait_drain(10);
        check("single_done_cnt", done_cnt, 1);

        // Back-to-back 8 ops at full throughput
        do_reset();
        out_ready = 1'b1;
        consec_en = 1'b1;
        last_cyc = -1;
        for (int i = 0; i < 8; i++) begin
            push(16'(1000 + 37 * i), 16'(i + 3), 3, ok);
            check("b2b_accept", {31'h0, ok}, 1);
        end
        wait_drain(20);
        consec_en = 1'b0;
        check("b2b_done_cnt", done_cnt, 8);

        // Backpressure: 4 FIFO + issue + output fill, then stall
        do_reset();
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 7; i++) begin
            push(va[i], vb[i], 3, ok);
            if (!ok) break;
            acc++;
        end
        check("bp_accepted", acc, 6);
        check("bp_in_ready", in_ready, 0);
        check("bp_stall_q", out_q, 10);
        check("bp_stall_r", out_r, 0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_hold_q", {out_valid, out_q, out_r}, {1'b1, 16'd10, 16'd0});
        out_ready = 1'b1;
        wait_drain(20);
        check("bp_done_cnt", done_cnt, 6);
        check("bp_idle", {busy, out_valid}, 0);

        // Divide by zero
        out_ready = 1'b0;
        push(16'd1234, 16'd0, 3, ok);
        repeat (2) @(posedge clk);
        #1;
        check("dz_valid", out_valid, 1);
`ifdef DIV_ZERO_CHECK_EN
        check("dz_q", out_q, 16'hFFFF);
        check("dz_r", out_r, 16'd1234);
        check("dz_err", out_err, 1);
`else
        check("dz_q", out_q, 16'h0BAD);
        check("dz_r", out_r, 16'h0F00);
        check("dz_err", out_err, 0);
`endif
        out_ready = 1'b1;
        wait_drain(10);

        // Reset with operands in flight
        out_ready = 1'b0;
        push(16'd5, 16'd1, 3, ok);
        push(16'd6, 16'd2, 3, ok);
        push(16'd7, 16'd3, 3, ok);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_qr", {out_q, out_r}, 0);
        check("mid_rst_div", {div_a, div_b}, 0);
        check("mid_rst_done_cnt", done_cnt, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_quiet", {busy, out_valid}, 0);
        check("post_rst_done_cnt", done_cnt, 0);

        // done_cnt wrap
        out_ready = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            push(16'(i), 16'((i % 13) + 1), 3, ok);
            if (!ok) begin
                check("wrap_accept", {31'h0, ok}, 1);
                break;
            end
        end
        wait_drain(20);
        check("wrap_preload", done_cnt, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            push(16'(500 + i), 16'(7 + i), 3, ok);
        end
        wait_drain(20);
        check("wrap_done_cnt", done_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
